// File: rtl/regfile_pkg.sv
// Shared definitions for the parametrised register file: clear-sequencer
// state encoding and the byte-merge helper used by the write and bypass paths.
package regfile_pkg;

  typedef enum logic [0:0] {
    IDLE     = 1'b0,
    CLEARING = 1'b1
  } clr_state_e;

  // Widest data word the merge helper supports; callers zero-extend into it.
  localparam int unsigned MERGE_MAX_W = 256;

  // Replace each byte of old_word whose enable is set with the same byte of new_word.
  function automatic logic [MERGE_MAX_W-1:0] byte_merge(
    input logic [MERGE_MAX_W-1:0]   old_word,
    input logic [MERGE_MAX_W-1:0]   new_word,
    input logic [MERGE_MAX_W/8-1:0] byte_en
  );
    logic [MERGE_MAX_W-1:0] res;
    res = old_word;
    for (int unsigned i = 0; i < MERGE_MAX_W / 8; i++) begin
      if (byte_en[i]) res[8*i +: 8] = new_word[8*i +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/regfile_clear_fsm.sv
// Clear sequencer: on a Clear request walks the array one entry per cycle,
// asserting busy for exactly DEPTH cycles.
module regfile_clear_fsm
  import regfile_pkg::*;
#(
  parameter int unsigned DEPTH  = 32,
  parameter int unsigned ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk_i,
  input  logic              rst_n_i,
  input  logic              clear_i,
  output logic              busy_o,
  output logic              clear_en_o,
  output logic [ADDR_W-1:0] clear_addr_o
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

  clr_state_e        state_q, state_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d;

  // Next-state: start on Clear from IDLE, step the counter, return after the last entry.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (clear_i) begin
          state_d = CLEARING;
          cnt_d   = '0;
        end
      end
      CLEARING: begin
        if (cnt_q == LAST_ADDR) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // State and counter registers, asynchronously reset to IDLE / 0.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  assign busy_o       = (state_q == CLEARING);
  assign clear_en_o   = busy_o;
  assign clear_addr_o = cnt_q;

endmodule

// File: rtl/regfile_param.sv
// Parametrised register file: two combinational read ports, byte-enabled
// write port A, full-word write port B, optional r0 hard-zero, optional
// write-to-read bypass and a multi-cycle clear sequencer.
module regfile_param
  import regfile_pkg::*;
#(
  parameter int unsigned WIDTH    = 32,
  parameter int unsigned DEPTH    = 32,
  parameter int unsigned ADDR_W   = $clog2(DEPTH),
  parameter int unsigned ZERO_REG = 1,
  parameter int unsigned BYPASS   = 0
) (
  input  logic                 Clk,
  input  logic                 ResetN,
  input  logic [ADDR_W-1:0]    ReadRegister1,
  input  logic [ADDR_W-1:0]    ReadRegister2,
  output logic [WIDTH-1:0]     ReadData1,
  output logic [WIDTH-1:0]     ReadData2,
  input  logic [ADDR_W-1:0]    WriteRegister,
  input  logic [WIDTH-1:0]     WriteData,
  input  logic [WIDTH/8-1:0]   WriteByteEn,
  input  logic                 RegWrite,
  input  logic [ADDR_W-1:0]    WriteRegister2,
  input  logic [WIDTH-1:0]     WriteData2,
  input  logic                 RegWrite2,
  input  logic                 Clear,
  output logic                 Busy
);

  localparam logic [ADDR_W:0] DEPTH_C = (ADDR_W + 1)'(DEPTH);

  function automatic logic in_range(input logic [ADDR_W-1:0] a);
    return ({1'b0, a} < DEPTH_C);
  endfunction

  function automatic logic is_zero_reg(input logic [ADDR_W-1:0] a);
    return (ZERO_REG != 0) && (a == '0);
  endfunction

  logic [WIDTH-1:0]  mem_q [DEPTH];
  logic [WIDTH-1:0]  mem_d [DEPTH];
  logic              busy;
  logic              clear_en;
  logic [ADDR_W-1:0] clear_addr;
  logic              wa_ok, wb_ok;
  logic [WIDTH-1:0]  old_a, merged_a;
  logic [ADDR_W-1:0] rd_addr [2];
  logic [WIDTH-1:0]  rd_data [2];

  regfile_clear_fsm #(
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_clear_fsm (
    .clk_i        (Clk),
    .rst_n_i      (ResetN),
    .clear_i      (Clear),
    .busy_o       (busy),
    .clear_en_o   (clear_en),
    .clear_addr_o (clear_addr)
  );

  // A write is live only when idle, in range and not aimed at a hard-zero r0.
  assign wa_ok = RegWrite  && !busy && in_range(WriteRegister)  && !is_zero_reg(WriteRegister);
  assign wb_ok = RegWrite2 && !busy && in_range(WriteRegister2) && !is_zero_reg(WriteRegister2);

  assign old_a    = in_range(WriteRegister) ? mem_q[WriteRegister] : '0;
  assign merged_a = WIDTH'(byte_merge(MERGE_MAX_W'(old_a), MERGE_MAX_W'(WriteData),
                                      (MERGE_MAX_W/8)'(WriteByteEn)));

  // Per-entry next value; clear and writes never coincide since writes need !busy.
  always_comb begin
    for (int unsigned i = 0; i < DEPTH; i++) begin
      mem_d[i] = mem_q[i];
      if (clear_en && clear_addr == ADDR_W'(i)) begin
        mem_d[i] = '0;
      end else if (wb_ok && WriteRegister2 == ADDR_W'(i)) begin
        mem_d[i] = WriteData2;
      end else if (wa_ok && WriteRegister == ADDR_W'(i)) begin
        mem_d[i] = merged_a;
      end
    end
  end

  // Storage array, asynchronously zeroed.
  always_ff @(posedge Clk or negedge ResetN) begin
    if (!ResetN) begin
      for (int unsigned i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      mem_q <= mem_d;
    end
  end

  assign rd_addr[0] = ReadRegister1;
  assign rd_addr[1] = ReadRegister2;

  // Read muxing: out-of-range and hard-zero r0 read 0; bypass prefers port B over merged port A.
  always_comb begin
    for (int unsigned p = 0; p < 2; p++) begin
      rd_data[p] = '0;
      if (in_range(rd_addr[p]) && !is_zero_reg(rd_addr[p])) begin
        rd_data[p] = mem_q[rd_addr[p]];
        if (BYPASS != 0) begin
          if (wb_ok && WriteRegister2 == rd_addr[p]) begin
            rd_data[p] = WriteData2;
          end else if (wa_ok && WriteRegister == rd_addr[p]) begin
            rd_data[p] = merged_a;
          end
        end
      end
    end
  end

  assign ReadData1 = rd_data[0];
  assign ReadData2 = rd_data[1];
  assign Busy      = busy;

endmodule

// File: tb/tb_regfile_param.sv
// Bench for regfile_param: two instances (default config, and DEPTH=24 with
// r0 writable and bypass on) driven by shared stimulus and checked against
// an array-based reference model every cycle, plus literal spot checks.
module tb_regfile_param;

  logic        Clk;
  logic        rstn;
  logic [4:0]  rr1, rr2, wr, wr2;
  logic [31:0] wd, wd2;
  logic [3:0]  wbe;
  logic        we, we2, clr;
  logic [31:0] rd1 [2];
  logic [31:0] rd2 [2];
  logic        busy [2];

  int total = 0;
  int bad   = 0;

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  regfile_param #(.WIDTH(32), .DEPTH(32), .ZERO_REG(1), .BYPASS(0)) u_dut0 (
    .Clk(Clk), .ResetN(rstn),
    .ReadRegister1(rr1), .ReadRegister2(rr2),
    .ReadData1(rd1[0]), .ReadData2(rd2[0]),
    .WriteRegister(wr), .WriteData(wd), .WriteByteEn(wbe), .RegWrite(we),
    .WriteRegister2(wr2), .WriteData2(wd2), .RegWrite2(we2),
    .Clear(clr), .Busy(busy[0])
  );

  regfile_param #(.WIDTH(32), .DEPTH(24), .ZERO_REG(0), .BYPASS(1)) u_dut1 (
    .Clk(Clk), .ResetN(rstn),
    .ReadRegister1(rr1), .ReadRegister2(rr2),
    .ReadData1(rd1[1]), .ReadData2(rd2[1]),
    .WriteRegister(wr), .WriteData(wd), .WriteByteEn(wbe), .RegWrite(we),
    .WriteRegister2(wr2), .WriteData2(wd2), .RegWrite2(we2),
    .Clear(clr), .Busy(busy[1])
  );

  // Reference model: plain array per instance plus clear progress.
  int unsigned dep [2] = '{32, 24};
  bit          zr  [2] = '{1'b1, 1'b0};
  bit          bp  [2] = '{1'b0, 1'b1};
  logic [31:0] mdl [2][32];
  bit          clr_act [2];
  int unsigned clr_idx [2];

  function automatic logic [31:0] merge(input logic [31:0] o, input logic [31:0] n, input logic [3:0] be);
    logic [31:0] r;
    r = o;
    for (int b = 0; b < 4; b++) if (be[b]) r[8*b +: 8] = n[8*b +: 8];
    return r;
  endfunction

  function automatic bit a_ok(input int p);
    return we && !clr_act[p] && (32'(wr) < dep[p]) && !(zr[p] && wr == 5'd0);
  endfunction

  function automatic bit b_ok(input int p);
    return we2 && !clr_act[p] && (32'(wr2) < dep[p]) && !(zr[p] && wr2 == 5'd0);
  endfunction

  function automatic logic [31:0] model_read(input int p, input logic [4:0] a);
    if (32'(a) >= dep[p] || (zr[p] && a == 5'd0)) return 32'd0;
    if (bp[p]) begin
      if (b_ok(p) && wr2 == a) return wd2;
      if (a_ok(p) && wr == a) return merge(mdl[p][a], wd, wbe);
    end
    return mdl[p][a];
  endfunction

  task automatic model_reset();
    for (int p = 0; p < 2; p++) begin
      for (int i = 0; i < 32; i++) mdl[p][i] = 32'd0;
      clr_act[p] = 1'b0;
      clr_idx[p] = 0;
    end
  endtask

  task automatic model_update();
    bit aok, bok;
    if (!rstn) begin
      model_reset();
      return;
    end
    for (int p = 0; p < 2; p++) begin
      aok = a_ok(p);
      bok = b_ok(p);
      if (clr_act[p]) begin
        mdl[p][clr_idx[p]] = 32'd0;
        clr_idx[p]++;
        if (clr_idx[p] == dep[p]) clr_act[p] = 1'b0;
      end else begin
        if (aok) mdl[p][wr] = merge(mdl[p][wr], wd, wbe);
        if (bok) mdl[p][wr2] = wd2;
        if (clr) begin
          clr_act[p] = 1'b1;
          clr_idx[p] = 0;
        end
      end
    end
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic compare_all();
    for (int p = 0; p < 2; p++) begin
      check($sformatf("dut%0d rd1 a=%0d", p, rr1), rd1[p], model_read(p, rr1));
      check($sformatf("dut%0d rd2 a=%0d", p, rr2), rd2[p], model_read(p, rr2));
      check($sformatf("dut%0d busy", p), {31'd0, busy[p]}, {31'd0, clr_act[p]});
    end
  endtask

  // One clock: compare at the falling edge, advance the model on the rising edge.
  task automatic step();
    @(negedge Clk);
    compare_all();
    @(posedge Clk);
    model_update();
    #1;
  endtask

  task automatic idle();
    we = 1'b0; we2 = 1'b0; clr = 1'b0;
  endtask

  task automatic wa(input logic [4:0] a, input logic [31:0] d, input logic [3:0] be);
    wr = a; wd = d; wbe = be; we = 1'b1;
  endtask

  task automatic wb(input logic [4:0] a, input logic [31:0] d);
    wr2 = a; wd2 = d; we2 = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, bad=%0d", bad);
    $fatal(1);
  end

  initial begin
    int cnt;
    rstn = 1'b0;
    rr1 = '0; rr2 = '0; wr = '0; wr2 = '0; wd = '0; wd2 = '0; wbe = '0;
    idle();
    model_reset();
    step();
    step();
    check("reset busy0", {31'd0, busy[0]}, 32'd0);
    check("reset rd1 r7", rd1[1], 32'd0);
    rstn = 1'b1;

    // Port A full-word write; bypass instance shows it before the edge.
    idle(); wa(5'd2, 32'd15, 4'hF); rr1 = 5'd2; rr2 = 5'd2;
    #1;
    check("bypass pre-edge dut1", rd1[1], 32'd15);
    check("no bypass pre-edge dut0", rd1[0], 32'd0);
    step();
    idle();
    #1;
    check("r2 rd1 dut0", rd1[0], 32'd15);
    check("r2 rd2 dut0", rd2[0], 32'd15);
    check("r2 rd1 dut1", rd1[1], 32'd15);

    // Byte-enabled merge.
    wa(5'd5, 32'hAABBCCDD, 4'hF); step();
    wa(5'd5, 32'h11223344, 4'b0101); step();
    idle(); rr1 = 5'd5;
    #1;
    check("byte merge dut0", rd1[0], 32'hAA22CC44);
    check("byte merge dut1", rd1[1], 32'hAA22CC44);

    // Same address on both ports: B wins; neighbour untouched.
    idle(); wb(5'd10, 32'd0); step();
    idle(); wa(5'd9, 32'd7, 4'hF); wb(5'd9, 32'd9); rr1 = 5'd9;
    #1;
    check("bypass B wins dut1", rd1[1], 32'd9);
    step();
    idle(); rr1 = 5'd9; rr2 = 5'd10;
    #1;
    check("B wins dut0", rd1[0], 32'd9);
    check("r10 isolated dut0", rd2[0], 32'd0);
    check("B wins dut1", rd1[1], 32'd9);

    // Register zero.
    wa(5'd0, 32'd30, 4'hF); step();
    idle(); rr1 = 5'd0;
    #1;
    check("r0 hard zero dut0", rd1[0], 32'd0);
    check("r0 writable dut1", rd1[1], 32'd30);

    // Fill, then clear; count busy cycles and try a dropped write.
    for (int i = 1; i < 32; i++) begin
      idle();
      if (i % 2 == 1) wa(5'(i), 32'(i), 4'hF);
      else wb(5'(i), 32'(i));
      step();
    end
    idle(); rr1 = 5'd20;
    #1;
    check("r20 filled dut0", rd1[0], 32'd20);
    clr = 1'b1;
    step();
    cnt = 0;
    for (int k = 0; k < 40; k++) begin
      idle();
      if (k == 3) wa(5'd20, 32'd55, 4'hF);
      rr1 = 5'd20; rr2 = 5'(k);
      #1;
      if (busy[0]) cnt++;
      step();
    end
    check("clear busy cycles dut0", 32'(cnt), 32'd32);
    idle();
    for (int a = 0; a < 32; a++) begin
      rr1 = 5'(a); rr2 = 5'(31 - a);
      #1;
      check($sformatf("cleared r%0d dut0", a), rd1[0], 32'd0);
      check($sformatf("cleared r%0d dut1", a), rd1[1], 32'd0);
      step();
    end

    // Reset in the middle of a clear sequence.
    wa(5'd6, 32'h66, 4'hF); step();
    idle(); clr = 1'b1; step();
    clr = 1'b0;
    for (int k = 0; k < 4; k++) step();
    rr1 = 5'd6;
    #1;
    check("r6 before reset dut0", rd1[0], 32'h66);
    rstn = 1'b0;
    #1;
    model_reset();
    check("busy drops on reset dut0", {31'd0, busy[0]}, 32'd0);
    check("busy drops on reset dut1", {31'd0, busy[1]}, 32'd0);
    check("r6 after reset dut0", rd1[0], 32'd0);
    step();
    rstn = 1'b1;
    wa(5'd7, 32'hCAFEF00D, 4'hF); rr1 = 5'd7;
    step();
    idle();
    #1;
    check("write after reset dut0", rd1[0], 32'hCAFEF00D);
    check("write after reset dut1", rd1[1], 32'hCAFEF00D);

    // Randomised traffic against the model.
    for (int n = 0; n < 600; n++) begin
      wr  = 5'($urandom_range(31));
      wr2 = ($urandom_range(3) == 0) ? wr : 5'($urandom_range(31));
      wd  = $urandom;
      wd2 = $urandom;
      wbe = 4'($urandom_range(15));
      we  = 1'($urandom_range(1));
      we2 = 1'($urandom_range(1));
      clr = ($urandom_range(39) == 0);
      rr1 = ($urandom_range(2) == 0) ? wr : 5'($urandom_range(31));
      rr2 = ($urandom_range(2) == 0) ? wr2 : 5'($urandom_range(31));
      step();
    end
    idle();
    step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/regfile_param.md
Name: regfile_param

Overview:
Parametrised successor to the 32x32 two-read/one-write register file.
- Configurable data width and depth.
- Register zero optionally hard-wired to zero.
- Two write ports (A with byte enables, B full-word) and optional write-to-read bypass.
- A multi-cycle Clear sequencer that zeroes the array one entry per cycle and reports Busy.
- Sits in the CPU datapath in place of the fixed regfile; read ports feed the ALU operand muxes.

Parameters:
WIDTH, 32, data width in bits; must be a multiple of 8.
DEPTH, 32, number of registers; must be at least 2.
ADDR_W, $clog2(DEPTH), address width; derived, never overridden.
ZERO_REG, 1, when 1 register 0 always reads 0 and ignores writes.
BYPASS, 0, when 1 a read of an address written this cycle returns the incoming write data.

Ports:
Clk  in  1  clock; all state updates on the positive edge.
ResetN  in  1  asynchronous active-low reset.
ReadRegister1  in  ADDR_W  read port 1 address.
ReadRegister2  in  ADDR_W  read port 2 address.
ReadData1  out  WIDTH  read port 1 data (combinational).
ReadData2  out  WIDTH  read port 2 data (combinational).
WriteRegister  in  ADDR_W  write port A address.
WriteData  in  WIDTH  write port A data.
WriteByteEn  in  WIDTH/8  write port A byte enables; bit i covers bits 8i+7..8i.
RegWrite  in  1  write port A enable.
WriteRegister2  in  ADDR_W  write port B address.
WriteData2  in  WIDTH  write port B data (always full word).
RegWrite2  in  1  write port B enable.
Clear  in  1  single-cycle request to zero the whole array.
Busy  out  1  high while the Clear sequence runs.

Behaviour:
- Reset: ResetN low asynchronously zeroes every register, the FSM goes to IDLE, the clear counter goes to 0, and Busy goes to 0. Holds while ResetN is low. Reset mid-Clear aborts the sequence, but the array is zero anyway.
- Reads:
  - Combinational from the array.
  - Address >= DEPTH reads 0.
  - With ZERO_REG=1, address 0 reads 0.
- Writes:
  - Port A: on posedge Clk when RegWrite=1 and Busy=0, each byte i with WriteByteEn[i]=1 is updated; other bytes are held.
  - Port B: on posedge Clk when RegWrite2=1 and Busy=0, the full word is written.
  - Same address on both ports: port B wins entirely, and port A's enabled bytes are discarded.
  - Address >= DEPTH is ignored.
  - ZERO_REG=1 with address 0 is ignored.
  - Write latency is 1 cycle: data is visible on reads after the edge.
- Bypass (BYPASS=1 only):
  - If a read address equals an active write address that is not suppressed, the read returns the post-write value for that cycle.
  - Post-write value: port B data; otherwise the stored word merged with port A's enabled bytes.
  - Suppressed writes (Busy, out of range, reg 0) are never forwarded.
- Clear FSM, states IDLE and CLEARING:
  - IDLE + Clear=1 at posedge: Busy=1, counter=0, go to CLEARING.
  - CLEARING: each cycle register[counter] is zeroed and the counter increments.
  - When counter = DEPTH-1 is cleared: go to IDLE and Busy=0 on the following edge. The sequence takes exactly DEPTH cycles.
  - Clear while CLEARING is ignored (no restart).
  - Clear and RegWrite in the same IDLE cycle: the write is performed, then the clear starts (the write is later erased).
  - All writes during CLEARING are dropped.
  - Reads during CLEARING return current contents: entries below the counter are 0, the rest hold old values.

Decomposition:
- Shared package regfile_pkg holds:
  - FSM state encoding (IDLE=0, CLEARING=1).
  - A function computing the byte-merge of old word, new word and byte enables; used by both the write path and bypass.
- One natural sub-module: regfile_clear_fsm. It owns the state, counter and Busy, and outputs clear_en and clear_addr.
- The array, write arbitration and read/bypass muxing stay in the top.

Test Plan:
- Reset, then write 15 to r2 via port A with all bytes enabled -> ReadData1 = ReadData2 = 15 after one edge; with BYPASS=1, 15 appears before the edge.
- r5 = 32'hAABBCCDD, port A writes 32'h11223344 with WriteByteEn=4'b0101 -> r5 reads 32'hAA22CC44.
- Port A writes 7 to r9 and port B writes 9 to r9 in the same cycle -> r9 reads 9; r10, written to 0 previously, stays 0 (decoder isolation).
- Write 30 to r0 with ZERO_REG=1 -> reads 0. With ZERO_REG=0 -> reads 30.
- Fill r1..r31 with their own index, pulse Clear -> Busy high for exactly 32 cycles. A write of 55 to r20 during Busy is dropped. After Busy falls, all registers read 0.
- Pulse Clear, assert ResetN low at cycle 5 of the sequence -> Busy=0 immediately and all reads 0. After ResetN returns high, writes are accepted on the next edge.
